// File: rtl/vid5_fb_responder.sv
// Vid5I bus target: grants controller requests and serves burst reads/writes
// from an internal frame-buffer RAM.
module vid5_fb_responder #(
    parameter logic [3:0] TARGET_ID    = 4'd1,
    parameter int          MEM_WORDS    = 4096,
    parameter int          GRANT_DELAY  = 1,
    parameter int          READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  reqout,
    input  logic [3:0]  reqtar,
    input  logic [2:0]  cmdout,
    input  logic [31:0] addrdataout,
    input  logic [1:0]  lenout,
    output logic        ackin,
    output logic [2:0]  cmdin,
    output logic [31:0] addrdatain,
    output logic        selin,
    output logic [1:0]  lenin
);
    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [2:0] CMD_IDLE  = 3'd0;
    localparam logic [2:0] CMD_READ  = 3'd1;
    localparam logic [2:0] CMD_WRITE = 3'd2;
    localparam logic [2:0] CMD_DATA  = 3'd3;
    localparam logic [2:0] CMD_ERROR = 3'd7;

    localparam logic [3:0]    GD_LAST = 4'(GRANT_DELAY > 0 ? GRANT_DELAY - 1 : 0);
    localparam logic [3:0]    RL_LAST = 4'(READ_LATENCY > 1 ? READ_LATENCY - 2 : 0);
    localparam logic [AW-1:0] IDX_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE, S_GDLY, S_GRANT, S_ADDR, S_WDATA, S_RWAIT, S_RDATA, S_ERR
    } state_t;

    state_t        state;
    logic [AW-1:0] idx;
    logic [1:0]    len;
    logic [3:0]    cnt;
    logic [3:0]    dly;

    logic [31:0]   mem [MEM_WORDS];
    logic [AW-1:0] cmd_idx;
    logic [AW-1:0] rd_idx;
    logic [31:0]   rd_word;
    logic [3:0]    burst_n;
    logic          wr_en;

    assign cmd_idx = addrdataout[AW+1:2];
    // With a one-cycle read latency the first word is fetched straight from the address cycle.
    assign rd_idx  = (state == S_ADDR) ? cmd_idx : idx;
    assign rd_word = mem[rd_idx];
    assign burst_n = 4'd1 << len;
    assign wr_en   = (state == S_WDATA) && (cmdout == CMD_DATA);

    // NOTE: the RAM has no reset branch on purpose; contents survive reset and a reset
    // port would prevent mapping onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[idx] <= addrdataout;
    end

    // NOTE: every register here uses <= so all of them update together from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            idx        <= '0;
            len        <= '0;
            cnt        <= '0;
            dly        <= '0;
            ackin      <= 1'b0;
            cmdin      <= CMD_IDLE;
            addrdatain <= '0;
            selin      <= 1'b0;
            lenin      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (reqout != 2'd0 && reqtar == TARGET_ID) begin
                        dly <= '0;
                        if (GRANT_DELAY == 0) begin
                            state <= S_GRANT;
                            ackin <= 1'b1;
                        end else begin
                            state <= S_GDLY;
                        end
                    end
                end
                S_GDLY: begin
                    if (dly == GD_LAST) begin
                        state <= S_GRANT;
                        ackin <= 1'b1;
                    end else begin
                        dly <= dly + 4'd1;
                    end
                end
                S_GRANT: begin
                    ackin <= 1'b0;
                    state <= S_ADDR;
                end
                S_ADDR: begin
                    if (cmdout == CMD_IDLE) begin
                        if (reqout == 2'd0)
                            state <= S_IDLE;
                    end else if (cmdout == CMD_READ || cmdout == CMD_WRITE) begin
                        idx <= cmd_idx;
                        len <= lenout;
                        cnt <= '0;
                        dly <= '0;
                        if (cmdout == CMD_WRITE) begin
                            state <= S_WDATA;
                        end else if (READ_LATENCY == 1) begin
                            state      <= S_RDATA;
                            cmdin      <= CMD_DATA;
                            selin      <= 1'b1;
                            lenin      <= lenout;
                            addrdatain <= rd_word;
                            idx        <= cmd_idx + IDX_ONE;
                            cnt        <= 4'd1;
                        end else begin
                            state <= S_RWAIT;
                        end
                    end else begin
                        state      <= S_ERR;
                        cmdin      <= CMD_ERROR;
                        selin      <= 1'b1;
                        addrdatain <= '0;
                    end
                end
                S_WDATA: begin
                    if (cmdout == CMD_DATA) begin
                        idx <= idx + IDX_ONE;
                        cnt <= cnt + 4'd1;
                        if (cnt + 4'd1 == burst_n)
                            state <= S_IDLE;
                    end else if (cmdout != CMD_IDLE) begin
                        state      <= S_ERR;
                        cmdin      <= CMD_ERROR;
                        selin      <= 1'b1;
                        addrdatain <= '0;
                    end
                end
                S_RWAIT: begin
                    if (dly == RL_LAST) begin
                        state      <= S_RDATA;
                        cmdin      <= CMD_DATA;
                        selin      <= 1'b1;
                        lenin      <= len;
                        addrdatain <= rd_word;
                        idx        <= idx + IDX_ONE;
                        cnt        <= 4'd1;
                    end else begin
                        dly <= dly + 4'd1;
                    end
                end
                S_RDATA: begin
                    if (cnt == burst_n) begin
                        state      <= S_IDLE;
                        cmdin      <= CMD_IDLE;
                        selin      <= 1'b0;
                        lenin      <= '0;
                        addrdatain <= '0;
                    end else begin
                        addrdatain <= rd_word;
                        idx        <= idx + IDX_ONE;
                        cnt        <= cnt + 4'd1;
                    end
                end
                S_ERR: begin
                    state      <= S_IDLE;
                    cmdin      <= CMD_IDLE;
                    selin      <= 1'b0;
                    addrdatain <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
